// File: rtl/delay_attempt_scheduler.sv
// delay_attempt_scheduler: concurrent "a, then b exactly DELAY cycles later" attempt tracker with saturating counters.
// Define SCHED_COVER_EN to compile the cover points and the match/fail exclusivity assertion.
module delay_attempt_scheduler #(
    parameter int NUM_SLOTS = 4,
    parameter int DELAY     = 1,
    parameter int CNT_W     = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           a,
    input  logic                           b,
    output logic                           match,
    output logic                           fail,
    output logic                           drop,
    output logic                           busy,
    output logic [$clog2(NUM_SLOTS+1)-1:0] occupancy,
    output logic [CNT_W-1:0]               match_count,
    output logic [CNT_W-1:0]               fail_count,
    output logic [CNT_W-1:0]               drop_count
);
    localparam int CW = $clog2(DELAY + 1);
    localparam int OW = $clog2(NUM_SLOTS + 1);

    generate
        if (DELAY < 1 || NUM_SLOTS < 1) begin : g_bad_cfg
            $error("delay_attempt_scheduler: DELAY and NUM_SLOTS must be >= 1");
        end
    endgenerate

    logic [NUM_SLOTS-1:0] active, retire, alloc;
    logic [CW-1:0]        cnt [NUM_SLOTS];
    logic                 taken, full, any_ret;

    // A slot retiring this cycle is still busy, so it can never be re-claimed in its retire cycle.
    always_comb begin
        retire    = '0;
        alloc     = '0;
        taken     = 1'b0;
        occupancy = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            retire[i] = active[i] && cnt[i] == CW'(1);
            alloc[i]  = a && !rst && !active[i] && !taken;
            taken     = taken | !active[i];
            occupancy = occupancy + OW'(active[i]);
        end
    end

    assign full    = &active;
    assign any_ret = |retire;
    assign busy    = |active;
    assign match   = !rst && any_ret && b;
    assign fail    = !rst && any_ret && !b;
    assign drop    = !rst && a && full;

    always_ff @(posedge clk) begin
        if (rst) begin
            active      <= '0;
            match_count <= '0;
            fail_count  <= '0;
            drop_count  <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (retire[i]) active[i] <= 1'b0;
                else if (active[i]) cnt[i] <= cnt[i] - CW'(1);
                else if (alloc[i]) begin
                    active[i] <= 1'b1;
                    cnt[i]    <= CW'(DELAY);
                end
            end
            if (match && ~&match_count) match_count <= match_count + CNT_W'(1);
            if (fail && ~&fail_count) fail_count <= fail_count + CNT_W'(1);
            if (drop && ~&drop_count) drop_count <= drop_count + CNT_W'(1);
        end
    end

`ifdef SCHED_COVER_EN
    cov_match: cover property (@(posedge clk) disable iff (rst) match);
    cov_fail:  cover property (@(posedge clk) disable iff (rst) fail);
    cov_drop:  cover property (@(posedge clk) disable iff (rst) drop);
    cov_full:  cover property (@(posedge clk) disable iff (rst) occupancy == OW'(NUM_SLOTS));
    cov_swap:  cover property (@(posedge clk) disable iff (rst) any_ret && |alloc);
    ast_excl:  assert property (@(posedge clk) disable iff (rst) !(match && fail));
`else
    // Default build carries no checking logic; outputs are unaffected.
`endif
endmodule

// File: tb/tb_delay_attempt_scheduler.sv
// tb_delay_attempt_scheduler: queue-based reference model feeding a scoreboard, directed plus random stimulus.
module tb_delay_attempt_scheduler;
    localparam int NS  = 2;
    localparam int DL  = 3;
    localparam int CW  = 4;
    localparam int OW  = $clog2(NS + 1);
    localparam int MAX = (1 << CW) - 1;

    logic clk = 1'b0, rst = 1'b1, a = 1'b0, b = 1'b0;
    logic match, fail, drop, busy;
    logic [OW-1:0] occupancy;
    logic [CW-1:0] match_count, fail_count, drop_count;

    typedef struct {
        int   cyc;
        logic m, f, d, bz;
        int   occ, mc, fc, dc;
    } exp_t;

    exp_t sb[$];
    int   due_q[$];
    int   t = 0, mc = 0, fc = 0, dc = 0;
    int   errors = 0, checks = 0;
    exp_t me;

    delay_attempt_scheduler #(.NUM_SLOTS(NS), .DELAY(DL), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .a(a), .b(b),
        .match(match), .fail(fail), .drop(drop), .busy(busy),
        .occupancy(occupancy),
        .match_count(match_count), .fail_count(fail_count), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int cyc, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, cyc, act, req);
        end
    endtask

    // Model: each live attempt is just its due cycle; occupancy is the number of live attempts.
    task automatic step(input logic ia, input logic ib, input logic ir);
        exp_t e;
        bit   ret, drp;
        @(posedge clk);
        #1;
        a = ia; b = ib; rst = ir;
        ret   = due_q.size() > 0 && due_q[0] == t;
        drp   = ia && !ir && due_q.size() == NS;
        e.cyc = t;
        e.m   = !ir && ret && ib;
        e.f   = !ir && ret && !ib;
        e.d   = drp;
        e.bz  = due_q.size() > 0;
        e.occ = due_q.size();
        e.mc  = mc; e.fc = fc; e.dc = dc;
        sb.push_back(e);
        if (ir) begin
            due_q.delete();
            mc = 0; fc = 0; dc = 0;
        end else begin
            if (ret) void'(due_q.pop_front());
            if (ia && !drp) due_q.push_back(t + DL);
            if (e.m && mc < MAX) mc++;
            if (e.f && fc < MAX) fc++;
            if (e.d && dc < MAX) dc++;
        end
        t++;
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            me = sb.pop_front();
            chk("match", me.cyc, int'(match), int'(me.m));
            chk("fail", me.cyc, int'(fail), int'(me.f));
            chk("drop", me.cyc, int'(drop), int'(me.d));
            chk("busy", me.cyc, int'(busy), int'(me.bz));
            chk("occupancy", me.cyc, int'(occupancy), me.occ);
            chk("match_count", me.cyc, int'(match_count), me.mc);
            chk("fail_count", me.cyc, int'(fail_count), me.fc);
            chk("drop_count", me.cyc, int'(drop_count), me.dc);
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        // Back-to-back attempts beyond capacity: drops in the 3rd and 4th cycle.
        repeat (4) step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        // Reset while an attempt is in flight discards it.
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        repeat (4) step(1'b0, 1'b1, 1'b0);
        // Overlapping stream with b held high.
        repeat (20) step(1'b1, 1'b1, 1'b0);
        repeat (500) step($urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)), $urandom_range(0, 199) == 0);
        repeat (6) step(1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", t, sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
